hilbert_bin_shaper: RTL and testbench



---
 rtl/hilbert_bin_shaper.sv | 123 ++++++++++++
 tb/tb_hilbert_bin_shaper.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hilbert_bin_shaper.sv
// rtl/hilbert_bin_shaper.sv - captures a 32-bin FFT frame and streams it shaped by -j*sgn(k)
// Bins are stored in natural order at capture; shaping is applied on the read side.
module hilbert_bin_shaper #(
  parameter int N = 32,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N*W-1:0] br_flat,
  input  logic [N*W-1:0] bi_flat,
  input  logic           load,
  input  logic           out_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_re,
  output logic [W-1:0]   out_im,
  output logic [4:0]     out_index,
  output logic           out_last,
  output logic           busy,
  output logic           overrun
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   cap_re [N];
  logic [W-1:0]   cap_im [N];
  logic [4:0]     index;
  logic           accept, xfer, drop;
  logic [W-1:0]   bin_r, bin_i;

  // FFT port order: even ports carry k=0..15, odd ports carry k=16..31
  function automatic int port_of(input int k);
    return (k < 16) ? 2 * k : 2 * k - 31;
  endfunction

  function automatic logic [W-1:0] sat_neg(input logic [W-1:0] x);
    logic [W-1:0] most_neg;
    most_neg = {1'b1, {(W-1){1'b0}}};
    return (x == most_neg) ? ~most_neg : -x;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    xfer      = 1'b0;
    drop      = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          accept   = 1'b1;
          state_nx = STREAM;
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        xfer      = out_ready;
        // only the final transfer can accept a new frame without a bubble
        if (xfer && index == 5'd31) begin
          if (load) accept = 1'b1;
          else      state_nx = IDLE;
        end else if (load) begin
          drop = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index   <= 5'd0;
      overrun <= 1'b0;
      for (int k = 0; k < N; k++) begin
        cap_re[k] <= '0;
        cap_im[k] <= '0;
      end
    end else begin
      if (accept) begin
        index <= 5'd0;
        for (int k = 0; k < N; k++) begin
          cap_re[k] <= br_flat[port_of(k)*W +: W];
          cap_im[k] <= bi_flat[port_of(k)*W +: W];
        end
      end else if (xfer) begin
        index <= (index == 5'd31) ? 5'd0 : index + 5'd1;
      end
      if (drop) overrun <= 1'b1;
    end
  end

  assign bin_r = cap_re[index];
  assign bin_i = cap_im[index];

  always_comb begin
    out_re    = '0;
    out_im    = '0;
    out_index = 5'd0;
    out_last  = 1'b0;
    if (out_valid) begin
      out_index = index;
      out_last  = (index == 5'd31);
      if (index == 5'd0 || index == 5'd16) begin
        out_re = '0;
        out_im = '0;
      end else if (index < 5'd16) begin
        out_re = bin_i;
        out_im = sat_neg(bin_r);
      end else begin
        out_re = sat_neg(bin_i);
        out_im = bin_r;
      end
    end
  end

endmodule

// File: tb/tb_hilbert_bin_shaper.sv
// tb/tb_hilbert_bin_shaper.sv - directed self-checking bench for hilbert_bin_shaper
module tb_hilbert_bin_shaper;

  logic           clk = 1'b0;
  logic           reset;
  logic [1023:0]  br_flat, bi_flat;
  logic           load, out_ready;
  logic           out_valid, out_last, busy, overrun;
  logic [31:0]    out_re, out_im;
  logic [4:0]     out_index;

  int passed = 0;
  int total  = 0;

  hilbert_bin_shaper dut (
    .clk(clk), .reset(reset), .br_flat(br_flat), .bi_flat(bi_flat),
    .load(load), .out_ready(out_ready), .out_valid(out_valid),
    .out_re(out_re), .out_im(out_im), .out_index(out_index),
    .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // mode 0: br=k bi=100+k; mode 1: br=port bi=0; mode 2: all zero
  task automatic fill_frame(input int mode);
    int k;
    for (int p = 0; p < 32; p++) begin
      k = (p % 2 == 0) ? p / 2 : (p + 31) / 2;
      case (mode)
        0:       begin br_flat[p*32 +: 32] = 32'(k); bi_flat[p*32 +: 32] = 32'(100 + k); end
        1:       begin br_flat[p*32 +: 32] = 32'(p); bi_flat[p*32 +: 32] = 32'd0; end
        default: begin br_flat[p*32 +: 32] = 32'd0; bi_flat[p*32 +: 32] = 32'd0; end
      endcase
    end
  endtask

  task automatic pulse_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  function automatic logic [31:0] ere(input int k);
    if (k == 0 || k == 16) return 32'd0;
    if (k < 16) return 32'(100 + k);
    return 32'(-(100 + k));
  endfunction

  function automatic logic [31:0] eim(input int k);
    if (k == 0 || k == 16) return 32'd0;
    if (k < 16) return 32'(-k);
    return 32'(k);
  endfunction

  function automatic logic [31:0] eim_port(input int k);
    if (k == 0 || k == 16) return 32'd0;
    if (k < 16) return 32'(-2 * k);
    return 32'(2 * k - 31);
  endfunction

  initial begin
    int ek, cyc;
    bit stall, rdy;
    logic [31:0] pidx, pre, pim;

    reset = 1'b1; load = 1'b0; out_ready = 1'b0;
    br_flat = '0; bi_flat = '0;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_re", out_re, 32'd0);
    chk("rst_index", 32'(out_index), 32'd0);
    reset = 1'b0;
    tick();

    // basic frame
    fill_frame(0);
    out_ready = 1'b1;
    pulse_load();
    for (int k = 0; k < 32; k++) begin
      chk("basic_valid", 32'(out_valid), 32'd1);
      chk("basic_index", 32'(out_index), 32'(k));
      chk("basic_re", out_re, ere(k));
      chk("basic_im", out_im, eim(k));
      chk("basic_last", 32'(out_last), 32'(k == 31));
      tick();
    end
    chk("basic_k3_re", out_re, 32'd0);
    chk("basic_end_valid", 32'(out_valid), 32'd0);
    chk("basic_end_busy", 32'(busy), 32'd0);

    // port mapping
    fill_frame(1);
    pulse_load();
    for (int k = 0; k < 32; k++) begin
      chk("map_im", out_im, eim_port(k));
      chk("map_re", out_re, 32'd0);
      tick();
    end

    // saturation
    fill_frame(2);
    bi_flat[3*32 +: 32]  = 32'h8000_0000;
    br_flat[10*32 +: 32] = 32'h8000_0000;
    pulse_load();
    for (int k = 0; k < 32; k++) begin
      if (k == 17) chk("sat_k17_re", out_re, 32'h7FFF_FFFF);
      if (k == 5)  chk("sat_k5_im", out_im, 32'h7FFF_FFFF);
      if (k == 5)  chk("sat_k5_re", out_re, 32'd0);
      tick();
    end

    // backpressure
    fill_frame(0);
    out_ready = 1'b0;
    pulse_load();
    ek = 0; cyc = 0; stall = 1'b0;
    pidx = '0; pre = '0; pim = '0;
    while (ek < 32 && cyc < 400) begin
      if (stall) begin
        chk("bp_hold_idx", 32'(out_index), pidx);
        chk("bp_hold_re", out_re, pre);
        chk("bp_hold_im", out_im, pim);
      end
      rdy = 1'($urandom_range(0, 1));
      out_ready = rdy;
      if (out_valid && rdy) begin
        chk("bp_order", 32'(out_index), 32'(ek));
        chk("bp_re", out_re, ere(ek));
        ek++;
        stall = 1'b0;
      end else begin
        stall = out_valid;
        pidx = 32'(out_index); pre = out_re; pim = out_im;
      end
      tick();
      cyc++;
    end
    chk("bp_count", 32'(ek), 32'd32);
    chk("bp_end_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;

    // back-to-back
    fill_frame(0);
    pulse_load();
    for (int k = 0; k < 31; k++) tick();
    chk("b2b_idx31", 32'(out_index), 32'd31);
    chk("b2b_last", 32'(out_last), 32'd1);
    fill_frame(1);
    pulse_load();
    chk("b2b_valid", 32'(out_valid), 32'd1);
    chk("b2b_idx0", 32'(out_index), 32'd0);
    chk("b2b_overrun", 32'(overrun), 32'd0);
    tick();
    chk("b2b_k1_im", out_im, 32'hFFFF_FFFE);
    for (int k = 0; k < 30; k++) tick();
    chk("b2b_k31_im", out_im, 32'd31);
    tick();
    chk("b2b_end_valid", 32'(out_valid), 32'd0);

    // overrun
    fill_frame(0);
    pulse_load();
    for (int k = 0; k < 10; k++) tick();
    chk("ovr_idx10", 32'(out_index), 32'd10);
    fill_frame(1);
    pulse_load();
    chk("ovr_flag", 32'(overrun), 32'd1);
    chk("ovr_idx11", 32'(out_index), 32'd11);
    chk("ovr_k11_re", out_re, 32'd111);
    for (int k = 12; k < 32; k++) begin
      tick();
      chk("ovr_re", out_re, ere(k));
      chk("ovr_im", out_im, eim(k));
    end
    tick();
    chk("ovr_end_valid", 32'(out_valid), 32'd0);

    // reset mid-stream, then load held through reset
    fill_frame(0);
    pulse_load();
    for (int k = 0; k < 7; k++) tick();
    chk("mid_idx7", 32'(out_index), 32'd7);
    #2 reset = 1'b1;
    #1;
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_re", out_re, 32'd0);
    chk("mid_im", out_im, 32'd0);
    chk("mid_index", 32'(out_index), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_overrun", 32'(overrun), 32'd0);
    load = 1'b1;
    tick();
    load = 1'b0;
    reset = 1'b0;
    chk("rl_valid", 32'(out_valid), 32'd0);
    tick();
    chk("rl_valid2", 32'(out_valid), 32'd0);
    pulse_load();
    chk("fresh_valid", 32'(out_valid), 32'd1);
    chk("fresh_idx", 32'(out_index), 32'd0);
    tick();
    chk("fresh_k1_re", out_re, 32'd101);
    chk("fresh_k1_im", out_im, 32'hFFFF_FFFF);
    chk("fresh_overrun", 32'(overrun), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
